match_vec_serializer: RTL and testbench



---
 rtl/match_vec_serializer.sv | 87 ++++++++
 tb/tb_match_vec_serializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/match_vec_serializer.sv
// match_vec_serializer: streams set-bit indices of a tagged hit vector, lowest first, under valid/ready.
// Optional MATCH_VEC_SERIALIZER_EMPTY_NOTIFY_EN emits one flagged beat for an all-zero vector.
module priority_encoder #(
    parameter int W = 16
) (
    input  logic [W-1:0]         vec,
    output logic [$clog2(W)-1:0] index
);
    always_comb begin
        index = '0;
        for (int i = W - 1; i >= 0; i--)
            if (vec[i]) index = ($clog2(W))'(i);
    end
endmodule

module match_vec_serializer #(
    parameter int W     = 16,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_vec,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(W)-1:0] out_index,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_last,
    output logic                 out_empty
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [W-1:0]       pending, pending_nxt;
    logic [TAG_W-1:0]   tag_q, tag_nxt;
    logic               accept, fire;

    priority_encoder #(.W(W)) u_penc (.vec(pending), .index(out_index));

    assign out_valid = (state == BUSY);
    assign out_tag   = tag_q;
    assign out_last  = out_valid && ((pending & (pending - 1'b1)) == '0);
    assign fire      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (fire && out_last);
    assign accept    = in_valid && in_ready;

`ifdef MATCH_VEC_SERIALIZER_EMPTY_NOTIFY_EN
    localparam bit EMPTY_EN = 1'b1;
    logic empty_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) empty_q <= 1'b0;
        else        empty_q <= accept ? (in_vec == '0) : (fire ? 1'b0 : empty_q);
    assign out_empty = empty_q;
`else
    localparam bit EMPTY_EN = 1'b0;
    assign out_empty = 1'b0;
`endif

    // A new load overrides the clear of the bit just reported: the old vector is finished.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        tag_nxt     = tag_q;
        if (fire) begin
            pending_nxt = pending & ~({{(W-1){1'b0}}, 1'b1} << out_index);
            if (out_last) state_nxt = IDLE;
        end
        if (accept) begin
            pending_nxt = in_vec;
            tag_nxt     = in_tag;
            state_nxt   = (in_vec != '0 || EMPTY_EN) ? BUSY : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            tag_q   <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            tag_q   <= tag_nxt;
        end
endmodule

// File: tb/tb_match_vec_serializer.sv
// tb_match_vec_serializer: table vectors, corner sequences and a beat-queue reference model.
module tb_match_vec_serializer;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_vec = '0;
    logic [7:0]  in_tag = '0;
    logic        in_ready, out_valid, out_last, out_empty;
    logic [3:0]  out_index;
    logic [7:0]  out_tag;
    int          tests = 0, fails = 0;

    typedef struct {
        logic iv; logic [15:0] vec; logic [7:0] tag; logic ordy;
        logic ev; logic [3:0] eidx; logic [7:0] etag; logic elast; logic erdy;
    } row_t;
    typedef struct { int idx; logic [7:0] tag; bit last; bit empty; } beat_t;

    row_t  tbl[18];
    beat_t q[$];

    always #5 clk = ~clk;

    match_vec_serializer #(.W(16), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_tag(out_tag), .out_last(out_last), .out_empty(out_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] vec, input logic [7:0] tag, input logic ordy);
        @(negedge clk);
        in_valid = iv; in_vec = vec; in_tag = tag; out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    // Reference: every accepted vector expands into its beat list up front.
    task automatic model_push(input logic [15:0] vec, input logic [7:0] tag);
        int n = $countones(vec), k = 0;
`ifdef MATCH_VEC_SERIALIZER_EMPTY_NOTIFY_EN
        if (n == 0) q.push_back('{0, tag, 1'b1, 1'b1});
`endif
        for (int i = 0; i < 16; i++)
            if (vec[i]) begin
                k++;
                q.push_back('{i, tag, k == n, 1'b0});
            end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h8421, 8'h5A, 1'b1, 1'b0, 4'd0,  8'h00, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd0,  8'h5A, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd5,  8'h5A, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd10, 8'h5A, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd15, 8'h5A, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 16'h0001, 8'h01, 1'b1, 1'b0, 4'd0,  8'h5A, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 16'h0003, 8'h02, 1'b1, 1'b1, 4'd0,  8'h01, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd0,  8'h02, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd1,  8'h02, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 16'h0006, 8'h33, 1'b0, 1'b0, 4'd0,  8'h02, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 4'd1,  8'h33, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd1,  8'h33, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 16'hFFFF, 8'hEE, 1'b0, 1'b1, 4'd2,  8'h33, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 4'd2,  8'h33, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd2,  8'h33, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 16'h8000, 8'hA5, 1'b1, 1'b0, 4'd0,  8'h33, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 4'd15, 8'hA5, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 4'd0,  8'hA5, 1'b0, 1'b1};

        @(negedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_last", 32'(out_last), 0);
        check("reset_empty", 32'(out_empty), 0);
        check("reset_index", 32'(out_index), 0);
        check("reset_tag", 32'(out_tag), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].iv, tbl[r].vec, tbl[r].tag, tbl[r].ordy);
            check($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].ev));
            check($sformatf("tbl%0d_index", r), 32'(out_index), 32'(tbl[r].eidx));
            check($sformatf("tbl%0d_tag", r), 32'(out_tag), 32'(tbl[r].etag));
            check($sformatf("tbl%0d_last", r), 32'(out_last), 32'(tbl[r].elast));
            check($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].erdy));
            check($sformatf("tbl%0d_empty", r), 32'(out_empty), 0);
        end

        drive(1'b1, 16'h0000, 8'h07, 1'b1);
        check("zero_accept_ready", 32'(in_ready), 1);
        drive(1'b0, 16'h0000, 8'h00, 1'b1);
`ifdef MATCH_VEC_SERIALIZER_EMPTY_NOTIFY_EN
        check("zero_valid", 32'(out_valid), 1);
        check("zero_empty", 32'(out_empty), 1);
        check("zero_last", 32'(out_last), 1);
        check("zero_index", 32'(out_index), 0);
        check("zero_tag", 32'(out_tag), 32'h07);
`else
        check("zero_valid", 32'(out_valid), 0);
        check("zero_empty", 32'(out_empty), 0);
        check("zero_in_ready", 32'(in_ready), 1);
`endif
        drive(1'b0, 16'h0000, 8'h00, 1'b1);
        check("zero_after_valid", 32'(out_valid), 0);

        drive(1'b1, 16'h0F00, 8'h11, 1'b1);
        drive(1'b0, 16'h0000, 8'h00, 1'b1);
        check("midrst_beat0", 32'(out_index), 8);
        drive(1'b0, 16'h0000, 8'h00, 1'b1);
        check("midrst_beat1", 32'(out_index), 9);
        @(negedge clk);
        check("midrst_pre_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_now", 32'(out_valid), 0);
        check("midrst_ready_now", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 16'h0000, 8'h00, 1'b1);
            check("postrst_valid", 32'(out_valid), 0);
            check("postrst_ready", 32'(in_ready), 1);
        end

        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [15:0] v;
            logic        iv, ordy, exp_rdy;
            int          sel = $urandom_range(0, 4);
            v    = (sel == 0) ? 16'h0000 : (sel == 1) ? (16'h0001 << $urandom_range(0, 15)) : 16'($urandom);
            iv   = 1'($urandom_range(0, 2) != 0);
            ordy = 1'($urandom_range(0, 3) != 0);
            drive(iv, v, 8'($urandom), ordy);
            exp_rdy = (q.size() == 0) || (ordy && q.size() == 1);
            check("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            if (q.size() != 0) begin
                check("rnd_index", 32'(out_index), 32'(q[0].idx));
                check("rnd_tag", 32'(out_tag), 32'(q[0].tag));
                check("rnd_last", 32'(out_last), 32'(q[0].last));
                check("rnd_empty", 32'(out_empty), 32'(q[0].empty));
                if (ordy) void'(q.pop_front());
            end else
                check("rnd_idle_last", 32'(out_last), 0);
            if (iv && exp_rdy) model_push(in_vec, in_tag);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
